// File: rtl/coin_collector.sv
// Coin collector front end for a vending machine: counts NTD_5/NTD_1 coins,
// hands the counts and an ITEM_A request downstream, or refunds them on
// cancel or inactivity timeout.
module coin_collector #(
  parameter logic [3:0] TIMEOUT = 4'd15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coinPulse5,
  input  logic       coinPulse1,
  input  logic       selectA,
  input  logic       cancel,
  input  logic [1:0] serviceTypeIn,
  output logic [1:0] coinInNTD_5,
  output logic [1:0] coinInNTD_1,
  output logic       itemTypeIn,
  output logic [1:0] refundNTD_5,
  output logic [1:0] refundNTD_1,
  output logic       refundValid,
  output logic       coinReject5,
  output logic       coinReject1
);

  typedef enum logic [2:0] {StIdle, StCollect, StRequest, StWait, StRefund} state_e;

  state_e     state_q, state_d;
  logic [1:0] cnt5_q, cnt5_d, cnt1_q, cnt1_d;
  logic [3:0] timer_q, timer_d;
  logic       item_q, item_d;
  logic [1:0] refund5_q, refund5_d, refund1_q, refund1_d;
  logic       refund_valid_q, refund_valid_d;
  logic       reject5_q, reject5_d, reject1_q, reject1_d;

  logic can_take, accept5, accept1, handoff;

  // Coins are only taken while collecting and never past a count of 3.
  assign can_take = (state_q == StIdle) || (state_q == StCollect);
  assign accept5  = coinPulse5 && can_take && (cnt5_q != 2'd3);
  assign accept1  = coinPulse1 && can_take && (cnt1_q != 2'd3);
  // Downstream latches counts and request in the REQUEST cycle it reports ON.
  assign handoff  = (state_q == StRequest) && (serviceTypeIn == 2'b01);

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept5 || accept1) state_d = StCollect;
      end
      StCollect: begin
        if (cancel)                  state_d = StRefund;
        else if (selectA)            state_d = StRequest;
        else if (timer_q == TIMEOUT) state_d = StRefund;
      end
      StRequest: begin
        // Handoff wins over cancel: the coins are already committed downstream.
        if (handoff)     state_d = StWait;
        else if (cancel) state_d = StRefund;
      end
      StWait: begin
        if (serviceTypeIn == 2'b00) state_d = StIdle;
      end
      StRefund: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Next values for counters, timer and every registered output.
  always_comb begin
    cnt5_d = cnt5_q + {1'b0, accept5};
    cnt1_d = cnt1_q + {1'b0, accept1};
    if (handoff || (state_q == StRefund)) begin
      cnt5_d = 2'd0;
      cnt1_d = 2'd0;
    end

    // Timer only runs while staying in COLLECT; any other path clears it.
    timer_d = 4'd0;
    if ((state_q == StCollect) && (state_d == StCollect)) begin
      if (accept5 || accept1)   timer_d = 4'd0;
      else if (timer_q != 4'hf) timer_d = timer_q + 4'd1;
      else                      timer_d = timer_q;
    end

    item_d         = (state_d == StRequest);
    refund_valid_d = (state_d == StRefund);
    // Refund includes a coin accepted in the same cycle as cancel/timeout.
    refund5_d      = refund_valid_d ? cnt5_d : 2'd0;
    refund1_d      = refund_valid_d ? cnt1_d : 2'd0;
    reject5_d      = coinPulse5 && !accept5;
    reject1_d      = coinPulse1 && !accept1;
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt5_q         <= 2'd0;
      cnt1_q         <= 2'd0;
      timer_q        <= 4'd0;
      item_q         <= 1'b0;
      refund5_q      <= 2'd0;
      refund1_q      <= 2'd0;
      refund_valid_q <= 1'b0;
      reject5_q      <= 1'b0;
      reject1_q      <= 1'b0;
    end else begin
      cnt5_q         <= cnt5_d;
      cnt1_q         <= cnt1_d;
      timer_q        <= timer_d;
      item_q         <= item_d;
      refund5_q      <= refund5_d;
      refund1_q      <= refund1_d;
      refund_valid_q <= refund_valid_d;
      reject5_q      <= reject5_d;
      reject1_q      <= reject1_d;
    end
  end

  assign coinInNTD_5 = cnt5_q;
  assign coinInNTD_1 = cnt1_q;
  assign itemTypeIn  = item_q;
  assign refundNTD_5 = refund5_q;
  assign refundNTD_1 = refund1_q;
  assign refundValid = refund_valid_q;
  assign coinReject5 = reject5_q;
  assign coinReject1 = reject1_q;

endmodule

// File: tb/tb_coin_collector.sv
// Self-checking bench for coin_collector: each row drives one cycle of inputs
// and queues the outputs expected after that clock edge.
module tb_coin_collector;

  typedef struct packed {
    logic [1:0] c5;
    logic [1:0] c1;
    logic       item;
    logic [1:0] r5;
    logic [1:0] r1;
    logic       rv;
    logic       j5;
    logic       j1;
  } out_t;

  typedef struct packed {
    logic       rst_n;
    logic       p5;
    logic       p1;
    logic       sa;
    logic       cn;
    logic [1:0] svc;
    out_t       exp;
  } row_t;

  localparam out_t OZ = '0;

  logic       clk = 1'b0;
  logic       reset, coinPulse5, coinPulse1, selectA, cancel;
  logic [1:0] serviceTypeIn;
  logic [1:0] coinInNTD_5, coinInNTD_1, refundNTD_5, refundNTD_1;
  logic       itemTypeIn, refundValid, coinReject5, coinReject1;

  int   vectors = 0;
  int   miscompares = 0;
  out_t sb[$];
  out_t obs, expv;

  coin_collector #(.TIMEOUT(4'd15)) dut (
    .clk          (clk),
    .reset        (reset),
    .coinPulse5   (coinPulse5),
    .coinPulse1   (coinPulse1),
    .selectA      (selectA),
    .cancel       (cancel),
    .serviceTypeIn(serviceTypeIn),
    .coinInNTD_5  (coinInNTD_5),
    .coinInNTD_1  (coinInNTD_1),
    .itemTypeIn   (itemTypeIn),
    .refundNTD_5  (refundNTD_5),
    .refundNTD_1  (refundNTD_1),
    .refundValid  (refundValid),
    .coinReject5  (coinReject5),
    .coinReject1  (coinReject1)
  );

  always #5 clk = ~clk;

  function automatic out_t mko(int c5, int c1, int it = 0, int r5 = 0, int r1 = 0,
                               int rv = 0, int j5 = 0, int j1 = 0);
    out_t o;
    o.c5 = c5[1:0]; o.c1 = c1[1:0]; o.item = it[0];
    o.r5 = r5[1:0]; o.r1 = r1[1:0]; o.rv = rv[0];
    o.j5 = j5[0];   o.j1 = j1[0];
    return o;
  endfunction

  function automatic row_t mkrow(int rst_n, int p5, int p1, int sa, int cn, int svc, out_t e);
    row_t r;
    r.rst_n = rst_n[0]; r.p5 = p5[0]; r.p1 = p1[0];
    r.sa = sa[0]; r.cn = cn[0]; r.svc = svc[1:0]; r.exp = e;
    return r;
  endfunction

  function automatic out_t sample();
    return {coinInNTD_5, coinInNTD_1, itemTypeIn, refundNTD_5, refundNTD_1,
            refundValid, coinReject5, coinReject1};
  endfunction

  // Drive one cycle of inputs, queue its expectation, and step past the edge.
  task automatic apply(input row_t r);
    reset = r.rst_n; coinPulse5 = r.p5; coinPulse1 = r.p1;
    selectA = r.sa; cancel = r.cn; serviceTypeIn = r.svc;
    sb.push_back(r.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    rows.push_back(mkrow(0, 0, 0, 0, 0, 0, OZ));
    rows.push_back(mkrow(0, 1, 1, 1, 1, 1, OZ));
    rows.push_back(mkrow(1, 0, 0, 0, 0, 0, OZ));
    rows.push_back(mkrow(1, 0, 0, 1, 1, 0, OZ));       // selectA/cancel ignored in IDLE
    rows.push_back(mkrow(1, 1, 0, 0, 0, 0, mko(1, 0)));
    rows.push_back(mkrow(0, 1, 1, 0, 0, 0, OZ));
    foreach (rows[i]) begin
      apply(rows[i]);
      expv = sb.pop_front(); obs = sample(); vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL reset[%0d] got %b want %b", i, obs, expv);
      end
    end
  endtask

  task automatic test_purchase();
    row_t rows[$];
    rows.push_back(mkrow(0, 0, 0, 0, 0, 0, OZ));
    rows.push_back(mkrow(1, 1, 0, 0, 0, 0, mko(1, 0)));
    rows.push_back(mkrow(1, 1, 0, 0, 0, 0, mko(2, 0)));
    rows.push_back(mkrow(1, 0, 1, 0, 0, 0, mko(2, 1)));
    rows.push_back(mkrow(1, 0, 1, 0, 0, 0, mko(2, 2)));
    rows.push_back(mkrow(1, 0, 1, 0, 0, 0, mko(2, 3)));
    rows.push_back(mkrow(1, 0, 0, 1, 0, 1, mko(2, 3, 1)));   // enter REQUEST
    rows.push_back(mkrow(1, 0, 0, 0, 0, 1, OZ));             // handoff -> WAIT
    rows.push_back(mkrow(1, 1, 0, 0, 0, 1, mko(0, 0, 0, 0, 0, 0, 1, 0)));
    rows.push_back(mkrow(1, 0, 0, 0, 0, 0, OZ));             // OFF -> IDLE
    rows.push_back(mkrow(1, 0, 1, 0, 0, 0, mko(0, 1)));
    foreach (rows[i]) begin
      apply(rows[i]);
      expv = sb.pop_front(); obs = sample(); vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL purchase[%0d] got %b want %b", i, obs, expv);
      end
    end
  endtask

  task automatic test_reject();
    row_t rows[$];
    rows.push_back(mkrow(0, 0, 0, 0, 0, 0, OZ));
    rows.push_back(mkrow(1, 0, 1, 0, 0, 0, mko(0, 1)));
    rows.push_back(mkrow(1, 0, 1, 0, 0, 0, mko(0, 2)));
    rows.push_back(mkrow(1, 0, 1, 0, 0, 0, mko(0, 3)));
    rows.push_back(mkrow(1, 0, 1, 0, 0, 0, mko(0, 3, 0, 0, 0, 0, 0, 1)));
    rows.push_back(mkrow(1, 1, 1, 0, 0, 0, mko(1, 3, 0, 0, 0, 0, 0, 1)));
    rows.push_back(mkrow(1, 0, 0, 0, 0, 0, mko(1, 3)));
    rows.push_back(mkrow(1, 1, 0, 0, 0, 0, mko(2, 3)));
    rows.push_back(mkrow(1, 1, 0, 0, 0, 0, mko(3, 3)));
    rows.push_back(mkrow(1, 1, 0, 0, 0, 0, mko(3, 3, 0, 0, 0, 0, 1, 0)));
    rows.push_back(mkrow(1, 0, 0, 0, 0, 0, mko(3, 3)));
    foreach (rows[i]) begin
      apply(rows[i]);
      expv = sb.pop_front(); obs = sample(); vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL reject[%0d] got %b want %b", i, obs, expv);
      end
    end
  endtask

  task automatic test_cancel();
    row_t rows[$];
    rows.push_back(mkrow(0, 0, 0, 0, 0, 0, OZ));
    rows.push_back(mkrow(1, 1, 0, 0, 0, 0, mko(1, 0)));
    rows.push_back(mkrow(1, 0, 1, 0, 0, 0, mko(1, 1)));
    rows.push_back(mkrow(1, 0, 0, 0, 1, 0, mko(1, 1, 0, 1, 1, 1)));
    rows.push_back(mkrow(1, 0, 0, 0, 0, 0, OZ));
    rows.push_back(mkrow(1, 0, 0, 1, 1, 0, OZ));
    rows.push_back(mkrow(1, 1, 0, 0, 0, 0, mko(1, 0)));
    rows.push_back(mkrow(1, 0, 1, 0, 1, 0, mko(1, 1, 0, 1, 1, 1)));  // coin with cancel kept
    rows.push_back(mkrow(1, 0, 0, 0, 0, 0, OZ));
    rows.push_back(mkrow(1, 1, 0, 0, 0, 0, mko(1, 0)));
    rows.push_back(mkrow(1, 0, 0, 1, 1, 0, mko(1, 0, 0, 1, 0, 1)));  // cancel beats selectA
    rows.push_back(mkrow(1, 0, 0, 0, 0, 0, OZ));
    foreach (rows[i]) begin
      apply(rows[i]);
      expv = sb.pop_front(); obs = sample(); vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL cancel[%0d] got %b want %b", i, obs, expv);
      end
    end
  endtask

  task automatic test_timeout();
    row_t rows[$];
    rows.push_back(mkrow(0, 0, 0, 0, 0, 0, OZ));
    rows.push_back(mkrow(1, 1, 0, 0, 0, 0, mko(1, 0)));
    for (int k = 0; k < 15; k++) rows.push_back(mkrow(1, 0, 0, 0, 0, 0, mko(1, 0)));
    rows.push_back(mkrow(1, 0, 0, 0, 0, 0, mko(1, 0, 0, 1, 0, 1)));  // 16th cycle after coin
    rows.push_back(mkrow(1, 0, 0, 0, 0, 0, OZ));
    // A coin mid-wait restarts the idle timer.
    rows.push_back(mkrow(1, 1, 0, 0, 0, 0, mko(1, 0)));
    for (int k = 0; k < 10; k++) rows.push_back(mkrow(1, 0, 0, 0, 0, 0, mko(1, 0)));
    rows.push_back(mkrow(1, 0, 1, 0, 0, 0, mko(1, 1)));
    for (int k = 0; k < 15; k++) rows.push_back(mkrow(1, 0, 0, 0, 0, 0, mko(1, 1)));
    rows.push_back(mkrow(1, 0, 0, 0, 0, 0, mko(1, 1, 0, 1, 1, 1)));
    rows.push_back(mkrow(1, 0, 0, 0, 0, 0, OZ));
    foreach (rows[i]) begin
      apply(rows[i]);
      expv = sb.pop_front(); obs = sample(); vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL timeout[%0d] got %b want %b", i, obs, expv);
      end
    end
  endtask

  task automatic test_busy();
    row_t rows[$];
    rows.push_back(mkrow(0, 0, 0, 0, 0, 0, OZ));
    rows.push_back(mkrow(1, 1, 0, 0, 0, 0, mko(1, 0)));
    rows.push_back(mkrow(1, 1, 0, 0, 0, 0, mko(2, 0)));
    rows.push_back(mkrow(1, 0, 0, 1, 0, 2, mko(2, 0, 1)));
    for (int k = 0; k < 5; k++)
      rows.push_back(mkrow(1, 0, (k == 2) ? 1 : 0, 0, 0, 2,
                           mko(2, 0, 1, 0, 0, 0, 0, (k == 2) ? 1 : 0)));
    rows.push_back(mkrow(1, 0, 0, 0, 1, 1, OZ));   // handoff; cancel ignored
    rows.push_back(mkrow(1, 0, 0, 0, 0, 1, OZ));
    rows.push_back(mkrow(1, 0, 0, 0, 0, 0, OZ));
    rows.push_back(mkrow(1, 0, 1, 0, 0, 0, mko(0, 1)));
    rows.push_back(mkrow(1, 0, 0, 1, 0, 2, mko(0, 1, 1)));
    rows.push_back(mkrow(1, 0, 0, 0, 1, 0, mko(0, 1, 0, 0, 1, 1)));  // cancel while OFF
    rows.push_back(mkrow(1, 0, 0, 0, 0, 0, OZ));
    foreach (rows[i]) begin
      apply(rows[i]);
      expv = sb.pop_front(); obs = sample(); vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL busy[%0d] got %b want %b", i, obs, expv);
      end
    end
  endtask

  task automatic test_reset_mid();
    row_t rows[$];
    rows.push_back(mkrow(0, 0, 0, 0, 0, 0, OZ));
    rows.push_back(mkrow(1, 1, 0, 0, 0, 0, mko(1, 0)));
    rows.push_back(mkrow(1, 1, 0, 0, 0, 0, mko(2, 0)));
    rows.push_back(mkrow(1, 0, 0, 1, 0, 2, mko(2, 0, 1)));
    rows.push_back(mkrow(0, 0, 0, 0, 0, 2, OZ));   // reset in REQUEST
    rows.push_back(mkrow(1, 0, 0, 0, 0, 0, OZ));
    rows.push_back(mkrow(1, 0, 0, 0, 0, 0, OZ));
    rows.push_back(mkrow(1, 1, 0, 0, 0, 0, mko(1, 0)));
    rows.push_back(mkrow(0, 0, 0, 0, 1, 0, OZ));   // reset beats cancel
    rows.push_back(mkrow(1, 0, 0, 0, 0, 0, OZ));
    rows.push_back(mkrow(1, 1, 0, 0, 0, 0, mko(1, 0)));
    rows.push_back(mkrow(1, 0, 0, 0, 1, 0, mko(1, 0, 0, 1, 0, 1)));
    rows.push_back(mkrow(0, 0, 0, 0, 0, 0, OZ));   // reset in REFUND
    rows.push_back(mkrow(1, 0, 0, 0, 0, 0, OZ));
    foreach (rows[i]) begin
      apply(rows[i]);
      expv = sb.pop_front(); obs = sample(); vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL reset_mid[%0d] got %b want %b", i, obs, expv);
      end
    end
  endtask

  initial begin
    reset = 1'b0; coinPulse5 = 1'b0; coinPulse1 = 1'b0;
    selectA = 1'b0; cancel = 1'b0; serviceTypeIn = 2'b00;
    @(posedge clk);
    #1;
    test_reset();
    test_purchase();
    test_reject();
    test_cancel();
    test_timeout();
    test_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/coin_collector.md
COIN_COLLECTOR -- requirements
Module: coin_collector

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, default 4'd15, the idle cycles in COLLECT before an automatic refund (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on posedge clk.
REQ-004 coinPulse5  input  1  one NTD_5 coin inserted this cycle.
REQ-005 coinPulse1  input  1  one NTD_1 coin inserted this cycle.
REQ-006 selectA  input  1  user requests ITEM_A.
REQ-007 cancel  input  1  user aborts and wants coins back.
REQ-008 serviceTypeIn  input  2  downstream vending machine state: 00 OFF, 01 ON, 10 BUSY.
REQ-009 coinInNTD_5  output  2  NTD_5 count presented downstream.
REQ-010 coinInNTD_1  output  2  NTD_1 count presented downstream.
REQ-011 itemTypeIn  output  1  request to downstream: 1 ITEM_A, 0 ITEM_NONE.
REQ-012 refundNTD_5  output  2  NTD_5 coins returned; valid only with refundValid.
REQ-013 refundNTD_1  output  2  NTD_1 coins returned; valid only with refundValid.
REQ-014 refundValid  output  1  one-cycle refund strobe.
REQ-015 coinReject5  output  1  one-cycle strobe: the NTD_5 coin of the previous cycle was rejected.
REQ-016 coinReject1  output  1  one-cycle strobe: the NTD_1 coin of the previous cycle was rejected.

Function
REQ-017 All outputs SHALL be registered; the FSM SHALL have the states IDLE, COLLECT, REQUEST, WAIT and REFUND.
REQ-018 Counters cnt5 and cnt1 (2 bits each) SHALL drive coinInNTD_5 and coinInNTD_1 directly.
REQ-019 A coin SHALL be accepted only in IDLE or COLLECT and only when its counter is below 3; the counter increments by 1 on the next cycle.
REQ-020 A coin SHALL be rejected when its counter is at 3 or the FSM is in REQUEST, WAIT or REFUND; the matching coinReject strobe is high for exactly the next cycle and the counter is unchanged.
REQ-021 Simultaneous coinPulse5 and coinPulse1 SHALL be evaluated independently.
REQ-022 IDLE: an accepted coin SHALL move the FSM to COLLECT; selectA and cancel SHALL be ignored in IDLE.
REQ-023 COLLECT priority SHALL be cancel > selectA > timeout.
  - cancel -> REFUND.
  - selectA -> REQUEST (a coin in the same cycle is still accepted).
  - idle timer == TIMEOUT -> REFUND.
REQ-024 The 4-bit idle timer SHALL clear on entry to COLLECT and on every accepted coin, increment on each other COLLECT cycle, and saturate at 15.
REQ-025 REQUEST: itemTypeIn SHALL be 1 while in REQUEST, and the counters SHALL be held stable.
  - Handoff: a REQUEST cycle with serviceTypeIn==01 is the handoff cycle (downstream captures the counts and the request in that cycle).
  - Next cycle after handoff: FSM = WAIT, cnt5 = cnt1 = 0, itemTypeIn = 0.
REQ-026 In REQUEST, cancel SHALL move the FSM to REFUND only when serviceTypeIn != 01; during a handoff cycle cancel is ignored.
REQ-027 WAIT SHALL hold until serviceTypeIn==00 is sampled, then go to IDLE.
REQ-028 REFUND SHALL last exactly one cycle.
  - In that cycle: refundValid = 1, refundNTD_5 = cnt5, refundNTD_1 = cnt1.
  - Next cycle: counters = 0, refund outputs = 0, FSM = IDLE.
REQ-029 Counts SHALL never wrap: coin value conservation (accepted coins = handed-off coins + refunded coins) SHALL hold at all times.

Reset
REQ-030 When reset==0 at posedge clk, the FSM SHALL go to IDLE, and the counters, timer and all outputs SHALL become 0 in the following cycle, regardless of state.
REQ-031 Reset mid-REQUEST or mid-REFUND SHALL discard the held coins, with no refundValid issued.

Verification
REQ-032 Coins 5,5,1,1,1 on consecutive cycles, then selectA with serviceTypeIn=01 -> one REQUEST cycle with coinInNTD_5=2, coinInNTD_1=3, itemTypeIn=1; next cycle all outputs 0, FSM in WAIT.
REQ-033 Four NTD_1 pulses -> the 4th is rejected: coinReject1=1 for one cycle and coinInNTD_1 stays 3.
REQ-034 Coins 5,1, then cancel -> refundValid=1 for one cycle with refundNTD_5=1, refundNTD_1=1; counters 0 afterwards.
REQ-035 One NTD_5 coin, then TIMEOUT=15 idle cycles -> refundValid with refundNTD_5=1 exactly 16 cycles after the coin.
REQ-036 REQUEST held while serviceTypeIn=10 for 5 cycles, then 01 -> handoff happens only in the first 01 cycle; a coin during the wait is rejected.
REQ-037 reset=0 in REQUEST with coinInNTD_5=2 -> next cycle all outputs 0 and no refundValid.
